// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types and defaults for the 2-bit comparator
//
// Purpose : holds the default result-counter width and the 2-bit operand type
//           shared by comparator and its tests.
// Contents: CNT_W_DEFAULT (default counter width), operand_t (unsigned 0..3).
package comparator_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef logic [1:0] operand_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose : counts single-cycle increment requests, sticking at all-ones
//           instead of wrapping.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset, forces count to 0
//           inc   - add one this edge (ignored once saturated)
//           clr   - synchronous clear, wins over inc
//           count - current count, W bits
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/comparator.sv
// rtl/comparator.sv - registered 2-bit magnitude comparator with result counters
//
// Purpose : compares A = {a1,a0} against B = {b1,b0} (unsigned), registers a
//           one-hot gt/eq/lt result one cycle after an accepted pair, and
//           counts each result kind in a saturating counter.
// Ports   : clk, rst          - clock and asynchronous active-high reset
//           a1, a0, b1, b0    - operand bits (bit 1 is MSB)
//           in_valid          - operands are valid this cycle; no back-pressure
//           cnt_clr           - synchronous clear of all three counters
//           f1, f2, f3        - registered A>B, A==B, A<B (all zero = no result yet)
//           out_valid         - in_valid delayed by one cycle
//           gt_cnt, eq_cnt, lt_cnt - saturating counts of accepted results
module comparator
    import comparator_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a1,
    input  logic             a0,
    input  logic             b1,
    input  logic             b0,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             f1,
    output logic             f2,
    output logic             f3,
    output logic             out_valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    operand_t op_a;
    operand_t op_b;
    logic     is_gt;
    logic     is_eq;
    logic     is_lt;

    assign op_a  = {a1, a0};
    assign op_b  = {b1, b0};
    assign is_gt = (op_a > op_b);
    assign is_eq = (op_a == op_b);
    assign is_lt = (op_a < op_b);

    // Flags only move on an accepted pair, so they hold the last result
    // across idle cycles; out_valid tells the consumer when they are fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f1        <= 1'b0;
            f2        <= 1'b0;
            f3        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f1 <= is_gt;
                f2 <= is_eq;
                f3 <= is_lt;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_valid && is_gt),
        .clr   (cnt_clr),
        .count (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_valid && is_eq),
        .clr   (cnt_clr),
        .count (eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_valid && is_lt),
        .clr   (cnt_clr),
        .count (lt_cnt)
    );

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - self-checking bench for comparator
module tb_comparator;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             a1, a0, b1, b0;
    logic             in_valid;
    logic             cnt_clr;
    logic             f1, f2, f3;
    logic             out_valid;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

    int vectors;
    int checks;
    int miscompares;

    // Reference state: plain integers updated from the comparison rules.
    int m_f1, m_f2, m_f3, m_ov;
    int m_gt, m_eq, m_lt;

    comparator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a1        (a1),
        .a0        (a0),
        .b1        (b1),
        .b0        (b0),
        .in_valid  (in_valid),
        .cnt_clr   (cnt_clr),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .out_valid (out_valid),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt),
        .lt_cnt    (lt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_f1 = 0; m_f2 = 0; m_f3 = 0; m_ov = 0;
        m_gt = 0; m_eq = 0; m_lt = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Applies one clock edge to the model using the inputs held at that edge.
    task automatic model_edge();
        int a, b;
        a = 2 * int'(a1) + int'(a0);
        b = 2 * int'(b1) + int'(b0);
        m_ov = int'(in_valid);
        if (in_valid) begin
            m_f1 = (a > b)  ? 1 : 0;
            m_f2 = (a == b) ? 1 : 0;
            m_f3 = (a < b)  ? 1 : 0;
        end
        if (cnt_clr) begin
            m_gt = 0; m_eq = 0; m_lt = 0;
        end else if (in_valid) begin
            if (a > b)       m_gt = sat_inc(m_gt);
            else if (a == b) m_eq = sat_inc(m_eq);
            else             m_lt = sat_inc(m_lt);
        end
    endtask

    task automatic set_ops(input int a, input int b, input bit v, input bit clr);
        {a1, a0} = 2'(a);
        {b1, b0} = 2'(b);
        in_valid = v;
        cnt_clr  = clr;
    endtask

    // One clock edge: inputs must already be set; sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".f1"},        int'(f1),        m_f1);
        check({tag, ".f2"},        int'(f2),        m_f2);
        check({tag, ".f3"},        int'(f3),        m_f3);
        check({tag, ".out_valid"}, int'(out_valid), m_ov);
        check({tag, ".gt_cnt"},    int'(gt_cnt),    m_gt);
        check({tag, ".eq_cnt"},    int'(eq_cnt),    m_eq);
        check({tag, ".lt_cnt"},    int'(lt_cnt),    m_lt);
    endtask

    initial begin
        vectors     = 0;
        checks      = 0;
        miscompares = 0;
        model_reset();
        rst = 1'b1;
        set_ops(0, 0, 1'b0, 1'b0);

        // Reset state, before any clock edge and while edges run under reset.
        #2;
        compare_all("reset_noclk");
        set_ops(1, 2, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_clk");
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep of all 16 operand pairs, one per cycle.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                set_ops(a, b, 1'b1, 1'b0);
                step();
                compare_all($sformatf("sweep_%0d_%0d", a, b));
                if (a == 2 && b == 1) check("sweep_2gt1_f1", int'(f1), 1);
                if (a == 3 && b == 3) check("sweep_3eq3_f2", int'(f2), 1);
                if (a == 0 && b == 1) check("sweep_0lt1_f3", int'(f3), 1);
            end
        end
        check("sweep_gt_total", int'(gt_cnt), 6);
        check("sweep_eq_total", int'(eq_cnt), 4);
        check("sweep_lt_total", int'(lt_cnt), 6);

        // Hold: flags keep their value while in_valid is low.
        set_ops(3, 0, 1'b1, 1'b0);
        step();
        compare_all("hold_load");
        for (int i = 0; i < 3; i++) begin
            set_ops(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
            step();
            compare_all($sformatf("hold_%0d", i));
            check("hold_f1", int'(f1), 1);
            check("hold_out_valid", int'(out_valid), 0);
            check("hold_gt_cnt", int'(gt_cnt), 7);
        end

        // Asynchronous reset mid-cycle after activity.
        set_ops(0, 3, 1'b1, 1'b0);
        step();
        compare_all("pre_async");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        check("async_lt_cnt", int'(lt_cnt), 0);
        #2;
        rst = 1'b0;
        set_ops(2, 2, 1'b1, 1'b0);
        step();
        compare_all("fresh_accept");

        // Counter clear wins over a simultaneous increment; flags still load.
        set_ops(1, 0, 1'b1, 1'b0);
        step();
        set_ops(2, 3, 1'b1, 1'b1);
        step();
        compare_all("clr_with_valid");
        check("clr_f3", int'(f3), 1);
        check("clr_lt_cnt", int'(lt_cnt), 0);
        check("clr_gt_cnt", int'(gt_cnt), 0);

        // Saturation of the equality counter.
        for (int i = 0; i < 300; i++) begin
            set_ops(1, 1, 1'b1, 1'b0);
            step();
            compare_all("sat_run");
        end
        check("sat_eq_cnt", int'(eq_cnt), 255);

        // Randomized traffic with sparse counter clears and idle cycles.
        for (int i = 0; i < 600; i++) begin
            set_ops(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
            step();
            compare_all("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 The parameter SHALL be CNT_W, default 8, giving the width of each result-event counter.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-high reset.
REQ-004 The port a1 SHALL be an input, 1 bit wide, and is operand A bit 1 (MSB).
REQ-005 The port a0 SHALL be an input, 1 bit wide, and is operand A bit 0 (LSB).
REQ-006 The port b1 SHALL be an input, 1 bit wide, and is operand B bit 1 (MSB).
REQ-007 The port b0 SHALL be an input, 1 bit wide, and is operand B bit 0 (LSB).
REQ-008 The port in_valid SHALL be an input, 1 bit wide, and qualifies the operands this cycle.
REQ-009 The port cnt_clr SHALL be an input, 1 bit wide, and is a synchronous clear of all counters.
REQ-010 The port f1 SHALL be an output, 1 bit wide, and is registered A > B.
REQ-011 The port f2 SHALL be an output, 1 bit wide, and is registered A == B.
REQ-012 The port f3 SHALL be an output, 1 bit wide, and is registered A < B.
REQ-013 The port out_valid SHALL be an output, 1 bit wide, and marks f1/f2/f3 as updated this cycle.
REQ-014 The port gt_cnt SHALL be an output, CNT_W bits wide, and counts accepted A>B results.
REQ-015 The port eq_cnt SHALL be an output, CNT_W bits wide, and counts accepted A==B results.
REQ-016 The port lt_cnt SHALL be an output, CNT_W bits wide, and counts accepted A<B results.

Function
REQ-017 Operands SHALL be formed as A = {a1,a0} and B = {b1,b0}, both unsigned 0..3.
REQ-018 On a clk edge with in_valid=1, f1/f2/f3 SHALL load (A>B, A==B, A<B); latency is exactly 1 cycle.
REQ-019 Exactly one of f1, f2, f3 SHALL be 1 after any accepted operand pair (one-hot).
REQ-020 With in_valid=0, f1/f2/f3 SHALL hold their previous values.
REQ-021 out_valid SHALL equal in_valid delayed by one cycle.
REQ-022 Each accepted result SHALL increment exactly one counter (gt, eq or lt) by 1 in the same edge that loads the flags.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 cnt_clr=1 SHALL zero all three counters on the next edge, taking priority over a simultaneous increment; flags and out_valid are unaffected.
REQ-025 No handshake back-pressure SHALL exist; a new operand pair is accepted every cycle.

Reset
REQ-026 While rst=1, regardless of clk, f1=0, f2=0, f3=0, out_valid=0 and all counters = 0 (f1..f3 all zero means "no result yet").
REQ-027 rst asserted mid-stream SHALL discard the in-flight result; the first edge after deassertion with in_valid=1 behaves as a fresh accept.

Structure
REQ-028 A shared package SHALL hold CNT_W's default and a 2-bit operand typedef; no other constants are needed.
REQ-029 One sub-module, sat_counter (CNT_W-bit saturating counter with inc and clr), SHALL be instantiated three times; the compare logic stays in comparator.

Verification
REQ-030 The bench SHALL apply all 16 (A,B) combinations with in_valid=1, 1 per cycle; the required flags are f1=1 for A>B (e.g., A=2, B=1), f2=1 for A==B (e.g., 3,3) and f3=1 for A<B (e.g., 0,1), each one cycle later. After the sweep, the required counts are gt=6, eq=4 and lt=6.
REQ-031 The bench SHALL apply rst pulsed asynchronously between clk edges after activity; the required response is that all outputs drop to 0 immediately.
REQ-032 The bench SHALL apply A=3, B=0 with in_valid=1, then in_valid=0 for 3 cycles with the operands changing; the required response is that f1 stays 1, out_valid=0 and the counters remain unchanged.
REQ-033 The bench SHALL apply A=1, B=1 for 300 cycles with CNT_W=8; the required response is that eq_cnt saturates at 255.
REQ-034 The bench SHALL apply cnt_clr=1 together with in_valid=1 (A=2, B=3); the required response is that all counters = 0 next cycle and f3=1.
